// File: rtl/multi_edge_pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel edge-to-pulse generator.
// Optional input synchroniser is selected with MULTI_EDGE_PULSE_SYNC_EN.
package edge_pulse_pkg;

    typedef enum logic [1:0] {
        EM_OFF  = 2'b00,
        EM_RISE = 2'b01,
        EM_FALL = 2'b10,
        EM_BOTH = 2'b11
    } edge_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Requested length clamped to 1..max_len; zero is treated as one cycle.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/multi_edge_pulse_gen_if.sv
// Bus bundle for multi_edge_pulse_gen: level inputs, configuration and pulse outputs.
// No valid/ready handshake: x, mode and pulse_len are levels sampled every posedge, clr_missed is a one-cycle strobe.
interface multi_edge_pulse_gen_if #(
    parameter int N_CH    = 4,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
    logic [N_CH-1:0]   x;
    logic [2*N_CH-1:0] mode;
    logic [LEN_W-1:0]  pulse_len;
    logic              clr_missed;
    logic [N_CH-1:0]   y;
    logic              any_y;
    logic [N_CH-1:0]   missed;
    logic [N_CH-1:0]   dbg_active;

    modport master (
        output x, mode, pulse_len, clr_missed,
        input  y, any_y, missed, dbg_active
    );

    modport slave (
        input  x, mode, pulse_len, clr_missed,
        output y, any_y, missed, dbg_active
    );
endinterface

// File: rtl/multi_edge_pulse_gen_ch.sv
// One channel: optional 2-flop synchroniser, edge detect, pulse FSM/counter, sticky missed flag.
// MULTI_EDGE_PULSE_SYNC_EN adds the synchroniser ahead of x_q.
module edge_pulse_ch
    import edge_pulse_pkg::*;
#(
    parameter int LEN_W  = 4,
    parameter bit RETRIG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  edge_mode_e       mode,
    input  logic [LEN_W-1:0] load_val,
    input  logic             clr_missed,
    output logic             y,
    output logic             y_next,
    output logic             missed,
    output state_e           state
);
    logic x_s;

`ifdef MULTI_EDGE_PULSE_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], x};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= sync_d;
    end

    assign x_s = sync_q[1];
`else
    assign x_s = x;
`endif

    logic             x_q, x_d;
    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             missed_q, missed_d;
    logic             rise, fall, edge_det, miss;

    always_comb begin
        x_d  = x_s;
        rise = x_s & ~x_q;
        fall = ~x_s & x_q;
        case (mode)
            EM_RISE: edge_det = rise;
            EM_FALL: edge_det = fall;
            EM_BOTH: edge_det = rise | fall;
            default: edge_det = 1'b0;
        endcase
    end

    // The cnt==0 cycle is still ACTIVE, so an edge there retriggers or is missed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        miss    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (edge_det) begin
                    cnt_d   = load_val;
                    y_d     = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (edge_det && RETRIG) begin
                    cnt_d = load_val;
                end else begin
                    miss = edge_det;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        y_d     = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                y_d     = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        missed_d = miss | (missed_q & ~clr_missed);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q      <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            y_q      <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            missed_q <= missed_d;
        end
    end

    assign y      = y_q;
    assign y_next = y_d;
    assign missed = missed_q;
    assign state  = state_q;

endmodule

// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: N_CH independent channels plus a registered any_y.
// Build with MULTI_EDGE_PULSE_SYNC_EN to synchronise x inside each channel.
module multi_edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter bit RETRIG  = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    multi_edge_pulse_gen_if.slave  bus
);
    logic [LEN_W-1:0] load_val;
    logic [N_CH-1:0]  y_vec, y_next_vec, missed_vec, active_vec;
    logic             any_y_q, any_y_d;

    // Shared counter reload value is L-1, computed once for all channels.
    always_comb load_val = LEN_W'(eff_len(32'(bus.pulse_len), MAX_LEN) - 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_e st;

        edge_pulse_ch #(
            .LEN_W  (LEN_W),
            .RETRIG (RETRIG)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .x          (bus.x[i]),
            .mode       (edge_mode_e'(bus.mode[2*i +: 2])),
            .load_val   (load_val),
            .clr_missed (bus.clr_missed),
            .y          (y_vec[i]),
            .y_next     (y_next_vec[i]),
            .missed     (missed_vec[i]),
            .state      (st)
        );

        assign active_vec[i] = (st == ST_ACTIVE);
    end

    always_comb any_y_d = |y_next_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_y_q <= 1'b0;
        else       any_y_q <= any_y_d;
    end

    assign bus.y          = y_vec;
    assign bus.any_y      = any_y_q;
    assign bus.missed     = missed_vec;
    assign bus.dbg_active = active_vec;

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Self-checking bench: RETRIG=1 and RETRIG=0 instances share stimulus and are scored
// against a remaining-cycles reference model.
module tb_multi_edge_pulse_gen;
  import edge_pulse_pkg::*;

  localparam int N_CH    = 4;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
`ifdef MULTI_EDGE_PULSE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int VW = 2 * N_CH + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N_CH-1:0]   x;
  logic [2*N_CH-1:0] mode;
  logic [LEN_W-1:0]  pulse_len;
  logic              clr;

  multi_edge_pulse_gen_if #(.N_CH(N_CH), .MAX_LEN(MAX_LEN)) if_r ();
  multi_edge_pulse_gen_if #(.N_CH(N_CH), .MAX_LEN(MAX_LEN)) if_n ();

  assign if_r.x = x;  assign if_r.mode = mode;  assign if_r.pulse_len = pulse_len;  assign if_r.clr_missed = clr;
  assign if_n.x = x;  assign if_n.mode = mode;  assign if_n.pulse_len = pulse_len;  assign if_n.clr_missed = clr;

  multi_edge_pulse_gen #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .RETRIG(1'b1)) dut_r (
    .clk(clk), .reset(reset), .bus(if_r)
  );
  multi_edge_pulse_gen #(.N_CH(N_CH), .MAX_LEN(MAX_LEN), .RETRIG(1'b0)) dut_n (
    .clk(clk), .reset(reset), .bus(if_n)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [VW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: remaining high cycles per channel, index 0 = retrigger, 1 = no retrigger
  int rem [2][N_CH];
  bit mm  [2][N_CH];
  bit prv [N_CH];
  bit s1  [N_CH];
  bit s2  [N_CH];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      prv[c] = 0; s1[c] = 0; s2[c] = 0;
      for (int p = 0; p < 2; p++) begin rem[p][c] = 0; mm[p][c] = 0; end
    end
  endtask

  task automatic model_step();
    int len;
    bit xs, e, act, nm;
    bit [1:0] md;
    logic [VW-1:0] v;
    len = (pulse_len == 0) ? 1 : ((int'(pulse_len) > MAX_LEN) ? MAX_LEN : int'(pulse_len));
    for (int c = 0; c < N_CH; c++) begin
`ifdef MULTI_EDGE_PULSE_SYNC_EN
      xs = s2[c]; s2[c] = s1[c]; s1[c] = x[c];
`else
      xs = x[c];
`endif
      md = mode[2*c +: 2];
      e = (md[0] && xs && !prv[c]) || (md[1] && !xs && prv[c]);
      prv[c] = xs;
      for (int p = 0; p < 2; p++) begin
        act = rem[p][c] > 0;
        nm  = 0;
        if (e && (!act || p == 0)) begin
          rem[p][c] = len;
        end else begin
          nm = e;
          if (act) rem[p][c]--;
        end
        mm[p][c] = nm | (mm[p][c] & !clr);
      end
    end
    for (int p = 0; p < 2; p++) begin
      v = '0;
      for (int c = 0; c < N_CH; c++) begin
        v[c]            = rem[p][c] > 0;
        v[N_CH + 1 + c] = mm[p][c];
      end
      v[N_CH] = |v[N_CH-1:0];
      exp_q.push_back(v);
    end
  endtask

  // width counters on a selectable channel
  int hi_ch = 0;
  int hi_r, hi_n;

  task automatic tick();
    logic [VW-1:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("out_retrig", 32'({if_r.missed, if_r.any_y, if_r.y}), 32'(e));
    e = exp_q.pop_front();
    check("out_noretrig", 32'({if_n.missed, if_n.any_y, if_n.y}), 32'(e));
    if (if_r.y[hi_ch]) hi_r++;
    if (if_n.y[hi_ch]) hi_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_hi(input int ch);
    hi_ch = ch; hi_r = 0; hi_n = 0;
  endtask

  initial begin
    reset = 1'b1; x = '0; mode = '0; pulse_len = '0; clr = 1'b0;
    model_reset();
    #13;
    check("reset_y",      32'({if_r.y, if_n.y}), 32'h0);
    check("reset_any",    32'({if_r.any_y, if_n.any_y}), 32'h0);
    check("reset_missed", 32'({if_r.missed, if_n.missed}), 32'h0);
    @(negedge clk); reset = 1'b0;

    // pulse length 3 on a rising edge, nothing on the fall
    mode = 8'b0000_0001; pulse_len = 4'd3;
    ticks(2);
    clear_hi(0); x[0] = 1'b1; ticks(10);
    check("s1_width_r", 32'(hi_r), 32'd3);
    check("s1_width_n", 32'(hi_n), 32'd3);
    clear_hi(0); x[0] = 1'b0; ticks(6);
    check("s1_fall_none", 32'(hi_r + hi_n), 32'd0);

    // both-edge mode, five single-cycle pulses
    mode = 8'b0000_1100; pulse_len = 4'd1;
    clear_hi(1);
    for (int i = 0; i < 5; i++) begin x[1] = ~x[1]; ticks(4); end
    ticks(LAT);
    check("s2_pulses", 32'(hi_r), 32'd5);

    // retrigger vs ignore-and-flag
    mode = 8'b0000_0001; pulse_len = 4'd4; x = '0;
    ticks(4);
    clear_hi(0);
    x[0] = 1'b1; tick(); x[0] = 1'b0; tick(); x[0] = 1'b1; ticks(10);
    check("s3_width_r", 32'(hi_r), 32'd6);
    check("s3_width_n", 32'(hi_n), 32'd4);
    check("s3_missed_n", 32'(if_n.missed[0]), 32'd1);
    check("s3_missed_r", 32'(if_r.missed[0]), 32'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    check("s3_clr", 32'(if_n.missed), 32'd0);
    x[0] = 1'b0; ticks(4);

    // length boundaries
    pulse_len = 4'd0; clear_hi(0); x[0] = 1'b1; ticks(6);
    check("s4_len0", 32'(hi_r), 32'd1);
    x[0] = 1'b0; ticks(3);
    pulse_len = 4'd15; clear_hi(0); x[0] = 1'b1; ticks(12);
    check("s4_len15", 32'(hi_r), 32'd8);
    x[0] = 1'b0; ticks(3);
    pulse_len = 4'd5; clear_hi(0); x[0] = 1'b1; ticks(LAT);
    pulse_len = 4'd2; ticks(10);
    check("s4_len_change", 32'(hi_r), 32'd5);
    x[0] = 1'b0; ticks(3);

    // reset mid-pulse with a missed flag pending
    pulse_len = 4'd8;
    x[0] = 1'b1; tick(); x[0] = 1'b0; tick(); x[0] = 1'b1; ticks(LAT + 1);
    #2; reset = 1'b1; #1;
    check("s5_reset_y", 32'({if_r.y, if_n.y, if_r.any_y, if_n.any_y}), 32'h0);
    check("s5_reset_missed", 32'({if_r.missed, if_n.missed}), 32'h0);
    model_reset();
    @(negedge clk); reset = 1'b0;
    ticks(12);

    // mode off ignores toggles; enabling on a steady high gives no pulse
    mode = '0; clear_hi(0);
    for (int i = 0; i < 8; i++) begin x[0] = ~x[0]; ticks(2); end
    x[0] = 1'b1; ticks(LAT + 2);
    mode = 8'b0000_0001; ticks(6);
    check("s5_mode_off", 32'(hi_r + hi_n), 32'd0);

    // randomized traffic on all channels
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N_CH; c++) if ($urandom_range(0, 3) == 0) x[c] = ~x[c];
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 7) == 0) pulse_len = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    clr = 1'b0;

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_edge_pulse_gen.md
Name: multi_edge_pulse_gen

Overview:
- Multi-channel, parametrised successor to the single-bit level-to-pulse converter.
- Each channel detects rising, falling or both edges on a level input. Per-channel mode is selectable at run time.
- Each detected edge produces an output pulse whose length is programmable at run time.
- Retrigger policy is selectable; edges lost during an active pulse set a sticky flag.
- Sits between slow control/status levels (buttons, interrupts, handshake levels) and logic that needs single-event strobes.

Parameters:
- N_CH, 4, number of independent channels (1..32).
- MAX_LEN, 8, maximum pulse length in clock cycles (>=1).
- LEN_W, $clog2(MAX_LEN+1), width of the pulse_len input (derived; do not override).
- RETRIG, 1, 1 = an edge during an active pulse restarts the length counter; 0 = the edge is ignored and flagged as missed.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- x  in  N_CH  level inputs, one bit per channel.
- mode  in  2*N_CH  per-channel mode; channel i uses mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- pulse_len  in  LEN_W  pulse length in cycles, shared by all channels.
- clr_missed  in  1  synchronous clear of all missed flags.
- y  out  N_CH  output pulses.
- any_y  out  1  OR of all y bits, registered together with y.
- missed  out  N_CH  sticky missed-edge flags.

Behaviour:
- Reset (async assert, sync deassert assumed upstream): y=0, any_y=0, missed=0, per-channel x_q=0, counters=0.
- Because x_q resets to 0, a channel whose x is high at the first post-reset sample sees a rising edge.
- Each posedge: x_q[i] <= x[i].
  - rise[i] = x & ~x_q.
  - fall[i] = ~x & x_q.
  - edge[i] is selected by mode; mode 00 never produces an edge.
- Effective length: L = (pulse_len==0) ? 1 : min(pulse_len, MAX_LEN).
  - L is captured when a pulse starts; later pulse_len changes do not affect an active pulse.
- Latency: for a new level first sampled at posedge k, y[i] rises after posedge k and stays high for exactly L cycles.
- Per-channel FSM (two states):
  - IDLE: on edge, load cnt=L-1, y=1, go to ACTIVE.
  - ACTIVE, cnt>0, no edge: cnt--, y stays 1.
  - ACTIVE, cnt==0, no edge: y=0, go to IDLE.
  - ACTIVE with edge and RETRIG=1: reload cnt=L-1, y stays 1. The pulse is extended; no gap is inserted.
  - ACTIVE with edge and RETRIG=0: edge ignored, missed[i] set, pulse continues unchanged.
- The final pulse cycle (cnt==0) counts as ACTIVE:
  - An edge there reloads (RETRIG=1), or sets missed (RETRIG=0).
  - With RETRIG=0, the next edge is only accepted from IDLE.
- A mode change during ACTIVE does not cut the pulse short. The new mode applies to edge detection from the next posedge.
- The mode-00 channel still tracks x_q. Switching from 00 to another mode therefore does not produce a spurious edge from stale history.
- Missed flags:
  - clr_missed clears all flags.
  - If clr_missed and a new miss occur in the same cycle, set wins.
- any_y equals the OR of y, registered in the same cycle (no extra latency).
- Channels are fully independent; simultaneous edges on all channels are handled in the same cycle.

Optional Feature:
- Macro: MULTI_EDGE_PULSE_SYNC_EN.
- Defined: each x bit passes through a 2-flop synchroniser (reset to 0) before x_q. Input-to-y latency becomes 3 posedges instead of 1.
- Undefined: x is used directly and must already be synchronous to clk.

Decomposition:
- Package edge_pulse_pkg:
  - typedef enum logic [1:0] edge_mode_e {EM_OFF, EM_RISE, EM_FALL, EM_BOTH}.
  - typedef enum logic state_e {ST_IDLE, ST_ACTIVE}.
- Sub-module edge_pulse_ch: a single channel containing the synchroniser option, x_q, FSM, counter and missed flag.
- The top instantiates N_CH copies in a generate loop and builds any_y.

Test Plan:
- Pulse length: N_CH=4, mode ch0=01, pulse_len=3; x[0] 0->1 held for 10 cycles -> y[0] high exactly 3 cycles starting 1 cycle after the sample; x[0] 1->0 -> no pulse; missed=0.
- Both edges: mode ch1=11, pulse_len=1; x[1] toggles every 4 cycles, 5 toggles -> 5 single-cycle y[1] pulses, each 1 cycle after its toggle; any_y matches.
- Retrigger: RETRIG=1, pulse_len=4, rise, second rising edge 2 cycles after the first (x goes low for 1 cycle) -> y continuous 6 cycles. Repeat with RETRIG=0 -> y 4 cycles, missed set; clr_missed -> missed=0.
- Length boundaries: pulse_len=0 -> 1-cycle pulse; pulse_len=15 with MAX_LEN=8 -> 8-cycle pulse; pulse_len changed mid-pulse -> current pulse length unaffected.
- Reset mid-pulse and mode off: assert reset during ACTIVE -> y=0, missed=0 immediately (async). Mode 00 with x toggling -> y stays 0; switch to 01 while x is steady high -> no pulse.
- Sync option: with MULTI_EDGE_PULSE_SYNC_EN defined, rerun the first scenario -> y rises 3 posedges after x changes.
